// File: rtl/tl_rx_fc_update_checker_if.sv
// FC DLLP delivery bus from the data link layer to the TL RX flow-control checker.
// Single-cycle strobe, no backpressure: the checker samples every cycle dll_valid is high.
interface tl_rx_fc_update_checker_if #(
    parameter int CH_W   = 2,
    parameter int HDR_W  = 12,
    parameter int DATA_W = 16
);
    logic              dll_valid;
    logic [1:0]        dll_fc_type;
    logic [CH_W-1:0]   dll_ch;
    logic [HDR_W-1:0]  dll_hdr_creds;
    logic [DATA_W-1:0] dll_data_creds;
    logic [1:0]        dll_hdr_scale;
    logic [1:0]        dll_data_scale;

    modport master (
        output dll_valid, dll_fc_type, dll_ch, dll_hdr_creds,
               dll_data_creds, dll_hdr_scale, dll_data_scale
    );

    modport slave (
        input  dll_valid, dll_fc_type, dll_ch, dll_hdr_creds,
               dll_data_creds, dll_hdr_scale, dll_data_scale
    );
endinterface

// File: rtl/tl_rx_fc_update_checker.sv
// Per-channel FC init tracker and UpdateFC checker; latches advertised limits and
// scales, reports registered one-cycle error pulses with held channel/code.
module tl_rx_fc_update_checker #(
    parameter int NUM_CH = 3,
    parameter int HDR_W  = 12,
    parameter int DATA_W = 16,
    parameter int CH_W   = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     link_up,
    input  logic                     fc_chk_en,
    input  logic                     err_clr,
    tl_rx_fc_update_checker_if.slave dll,
    output logic [NUM_CH*HDR_W-1:0]  hdr_limit,
    output logic [NUM_CH*DATA_W-1:0] data_limit,
    output logic [NUM_CH-1:0]        hdr_infinite,
    output logic [NUM_CH-1:0]        data_infinite,
    output logic                     fc_init_done,
    output logic                     fc_error,
    output logic [CH_W-1:0]          fc_err_ch,
    output logic [2:0]               fc_err_code,
    output logic                     fc_err_sticky,
    output logic [NUM_CH*2-1:0]      dbg_ch_state
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_INIT1 = 2'd1, ST_ACTIVE = 2'd2} ch_state_e;

    localparam logic [1:0] T_INIT1 = 2'b00;
    localparam logic [1:0] T_INIT2 = 2'b01;
    localparam logic [1:0] T_UPD   = 2'b10;
    localparam logic [1:0] T_RSVD  = 2'b11;

    localparam logic [2:0] E_NONE  = 3'd0;
    localparam logic [2:0] E_SCALE = 3'd1;
    localparam logic [2:0] E_OVER  = 3'd2;
    localparam logic [2:0] E_INF   = 3'd3;
    localparam logic [2:0] E_MISM  = 3'd4;
    localparam logic [2:0] E_SEQ   = 3'd5;

    function automatic logic [HDR_W-1:0] hdr_max(input logic [1:0] s);
        case (s)
            2'b10:   return HDR_W'(511);
            2'b11:   return HDR_W'(2047);
            default: return HDR_W'(127);
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] data_max(input logic [1:0] s);
        case (s)
            2'b10:   return DATA_W'(8191);
            2'b11:   return DATA_W'(32767);
            default: return DATA_W'(2047);
        endcase
    endfunction

    ch_state_e         state_q    [NUM_CH];
    ch_state_e         state_d    [NUM_CH];
    logic [HDR_W-1:0]  hdr_lim_q  [NUM_CH];
    logic [DATA_W-1:0] data_lim_q [NUM_CH];
    logic [1:0]        hdr_scl_q  [NUM_CH];
    logic [1:0]        data_scl_q [NUM_CH];
    logic [NUM_CH-1:0] hdr_inf_q;
    logic [NUM_CH-1:0] data_inf_q;

    logic              init_done_q;
    logic              fc_error_q;
    logic [CH_W-1:0]   err_ch_q;
    logic [2:0]        err_code_q;
    logic              sticky_q;

    logic              ch_ok;
    logic [CH_W-1:0]   sel;
    logic [2:0]        err_code;
    logic              go_init1;
    logic              go_active;
    logic              upd_limit;
    logic              err_fire;
    logic              all_active_d;
    logic [HDR_W-1:0]  hdr_delta;
    logic [DATA_W-1:0] data_delta;
    logic              creds_match;

    // Only one DLLP arrives per cycle, so the addressed channel is evaluated once and muxed.
    assign ch_ok = dll.dll_valid && link_up && (dll.dll_fc_type != T_RSVD) &&
                   (int'(dll.dll_ch) < NUM_CH);
    assign sel   = ch_ok ? dll.dll_ch : '0;

    // Deltas use field-width wrap so a counter rolling past 2^W is still a small advance.
    assign hdr_delta   = dll.dll_hdr_creds - hdr_lim_q[sel];
    assign data_delta  = dll.dll_data_creds - data_lim_q[sel];
    assign creds_match = (dll.dll_hdr_creds == hdr_lim_q[sel]) &&
                         (dll.dll_data_creds == data_lim_q[sel]) &&
                         (dll.dll_hdr_scale == hdr_scl_q[sel]) &&
                         (dll.dll_data_scale == data_scl_q[sel]);

    always_comb begin
        err_code  = E_NONE;
        go_init1  = 1'b0;
        go_active = 1'b0;
        upd_limit = 1'b0;
        if (ch_ok) begin
            case (state_q[sel])
                ST_IDLE: begin
                    if (dll.dll_fc_type != T_INIT1) begin
                        err_code = E_SEQ;
                    end else if ((dll.dll_hdr_creds > hdr_max(dll.dll_hdr_scale)) ||
                                 (dll.dll_data_creds > data_max(dll.dll_data_scale))) begin
                        err_code = E_OVER;
                    end else begin
                        go_init1 = 1'b1;
                    end
                end
                ST_INIT1: begin
                    if (dll.dll_fc_type == T_UPD) begin
                        err_code = E_SEQ;
                    end else if (!creds_match) begin
                        err_code = E_MISM;
                    end else if (dll.dll_fc_type == T_INIT2) begin
                        go_active = 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    if (dll.dll_fc_type == T_UPD) begin
                        if ((dll.dll_hdr_scale != hdr_scl_q[sel]) ||
                            (dll.dll_data_scale != data_scl_q[sel])) begin
                            err_code = E_SCALE;
                        end else if ((hdr_inf_q[sel] && (dll.dll_hdr_creds != '0)) ||
                                     (data_inf_q[sel] && (dll.dll_data_creds != '0))) begin
                            err_code = E_INF;
                        end else if ((hdr_delta > hdr_max(hdr_scl_q[sel])) ||
                                     (data_delta > data_max(data_scl_q[sel]))) begin
                            err_code = E_OVER;
                        end else begin
                            upd_limit = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        all_active_d = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            state_d[c] = state_q[c];
            if (!link_up) begin
                state_d[c] = ST_IDLE;
            end else if (ch_ok && (int'(sel) == c)) begin
                if (go_init1) begin
                    state_d[c] = ST_INIT1;
                end else if (go_active) begin
                    state_d[c] = ST_ACTIVE;
                end
            end
            if (state_d[c] != ST_ACTIVE) begin
                all_active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= ST_IDLE;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= state_d[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                hdr_lim_q[c]  <= '0;
                data_lim_q[c] <= '0;
                hdr_scl_q[c]  <= '0;
                data_scl_q[c] <= '0;
            end
            hdr_inf_q  <= '0;
            data_inf_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ((int'(sel) == c) && (go_init1 || upd_limit)) begin
                    hdr_lim_q[c]  <= dll.dll_hdr_creds;
                    data_lim_q[c] <= dll.dll_data_creds;
                end
                if ((int'(sel) == c) && go_init1) begin
                    hdr_scl_q[c]  <= dll.dll_hdr_scale;
                    data_scl_q[c] <= dll.dll_data_scale;
                    hdr_inf_q[c]  <= (dll.dll_hdr_creds == '0);
                    data_inf_q[c] <= (dll.dll_data_creds == '0);
                end
            end
        end
    end

    assign err_fire = fc_chk_en && (err_code != E_NONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done_q <= 1'b0;
            fc_error_q  <= 1'b0;
            err_ch_q    <= '0;
            err_code_q  <= '0;
            sticky_q    <= 1'b0;
        end else begin
            init_done_q <= all_active_d;
            fc_error_q  <= err_fire;
            if (err_fire) begin
                err_ch_q   <= dll.dll_ch;
                err_code_q <= err_code;
            end
            if (err_fire) begin
                sticky_q <= 1'b1;
            end else if (err_clr) begin
                sticky_q <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign hdr_limit[g*HDR_W +: HDR_W]    = hdr_lim_q[g];
        assign data_limit[g*DATA_W +: DATA_W] = data_lim_q[g];
        assign dbg_ch_state[g*2 +: 2]         = state_q[g];
    end

    assign hdr_infinite  = hdr_inf_q;
    assign data_infinite = data_inf_q;
    assign fc_init_done  = init_done_q;
    assign fc_error      = fc_error_q;
    assign fc_err_ch     = err_ch_q;
    assign fc_err_code   = err_code_q;
    assign fc_err_sticky = sticky_q;

endmodule

// File: tb/tb_tl_rx_fc_update_checker.sv
// Directed bench for the FC update checker: expected error pulses go into a queue,
// a negedge monitor pops them as the DUT pulses fc_error; state/limits checked inline.
module tb_tl_rx_fc_update_checker;
  localparam int NUM_CH = 3;
  localparam int HDR_W  = 12;
  localparam int DATA_W = 16;
  localparam int CH_W   = 2;
  localparam int EW     = CH_W + 3;

  localparam logic [1:0] T_INIT1 = 2'b00;
  localparam logic [1:0] T_INIT2 = 2'b01;
  localparam logic [1:0] T_UPD   = 2'b10;
  localparam logic [1:0] T_RSVD  = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic link_up = 1'b0;
  logic fc_chk_en = 1'b0;
  logic err_clr = 1'b0;
  logic [NUM_CH*HDR_W-1:0]  hdr_limit;
  logic [NUM_CH*DATA_W-1:0] data_limit;
  logic [NUM_CH-1:0]        hdr_infinite;
  logic [NUM_CH-1:0]        data_infinite;
  logic                     fc_init_done;
  logic                     fc_error;
  logic [CH_W-1:0]          fc_err_ch;
  logic [2:0]               fc_err_code;
  logic                     fc_err_sticky;
  logic [NUM_CH*2-1:0]      dbg_ch_state;

  tl_rx_fc_update_checker_if #(.CH_W(CH_W), .HDR_W(HDR_W), .DATA_W(DATA_W)) dll_if ();

  tl_rx_fc_update_checker #(.NUM_CH(NUM_CH), .HDR_W(HDR_W), .DATA_W(DATA_W), .CH_W(CH_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .link_up       (link_up),
    .fc_chk_en     (fc_chk_en),
    .err_clr       (err_clr),
    .dll           (dll_if.slave),
    .hdr_limit     (hdr_limit),
    .data_limit    (data_limit),
    .hdr_infinite  (hdr_infinite),
    .data_infinite (data_infinite),
    .fc_init_done  (fc_init_done),
    .fc_error      (fc_error),
    .fc_err_ch     (fc_err_ch),
    .fc_err_code   (fc_err_code),
    .fc_err_sticky (fc_err_sticky),
    .dbg_ch_state  (dbg_ch_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  logic [EW-1:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] hlim(input int c);
    return 32'(hdr_limit[c*HDR_W +: HDR_W]);
  endfunction

  function automatic logic [31:0] dlim(input int c);
    return 32'(data_limit[c*DATA_W +: DATA_W]);
  endfunction

  function automatic logic [31:0] cst(input int c);
    return 32'(dbg_ch_state[c*2 +: 2]);
  endfunction

  // driver: called at posedge+1, occupies exactly one cycle
  task automatic send(input logic [1:0] t, input logic [CH_W-1:0] ch, input int h, input int d,
                      input logic [1:0] hs, input logic [1:0] ds, input logic [2:0] code);
    dll_if.dll_valid      = 1'b1;
    dll_if.dll_fc_type    = t;
    dll_if.dll_ch         = ch;
    dll_if.dll_hdr_creds  = HDR_W'(h);
    dll_if.dll_data_creds = DATA_W'(d);
    dll_if.dll_hdr_scale  = hs;
    dll_if.dll_data_scale = ds;
    if (code != 3'd0) exp_q.push_back({ch, code});
    @(posedge clk);
    #1;
    dll_if.dll_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // monitor: every error pulse must match the oldest expected error
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && fc_error) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL err_pulse: got ch=%0d code=%0d, required no error", fc_err_ch, fc_err_code);
        end else begin
          e = exp_q.pop_front();
          if ({fc_err_ch, fc_err_code} !== e) begin
            fails++;
            $display("FAIL err_pulse: got ch=%0d code=%0d, required ch=%0d code=%0d",
                     fc_err_ch, fc_err_code, e[EW-1:3], e[2:0]);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end

  initial begin
    dll_if.dll_valid      = 1'b0;
    dll_if.dll_fc_type    = 2'b00;
    dll_if.dll_ch         = '0;
    dll_if.dll_hdr_creds  = '0;
    dll_if.dll_data_creds = '0;
    dll_if.dll_hdr_scale  = 2'b00;
    dll_if.dll_data_scale = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hdr_limit", 32'(hdr_limit), 0);
    check("rst_data_limit", 32'(data_limit), 0);
    check("rst_init_done", 32'(fc_init_done), 0);
    check("rst_err_outs", {fc_error, fc_err_sticky, fc_err_ch, fc_err_code}, 0);
    check("rst_state", 32'(dbg_ch_state), 0);
    rst_n = 1'b1;
    link_up = 1'b1;
    fc_chk_en = 1'b1;
    idle(1);

    // init sequence, with a SEQ and an INIT_MISMATCH on NP
    send(T_INIT1, 0, 40, 400, 2'b01, 2'b01, 0);
    check("p_init1_state", cst(0), 1);
    send(T_INIT2, 0, 40, 400, 2'b01, 2'b01, 0);
    send(T_UPD,   1, 10, 10, 2'b01, 2'b01, 5);
    send(T_INIT1, 1, 50, 500, 2'b01, 2'b01, 0);
    send(T_INIT2, 1, 50, 401, 2'b01, 2'b01, 4);
    check("np_mismatch_stays_init1", cst(1), 1);
    send(T_INIT2, 1, 50, 500, 2'b01, 2'b01, 0);
    send(T_INIT1, 2, 0, 600, 2'b01, 2'b01, 0);
    check("init_done_partial", 32'(fc_init_done), 0);
    send(T_INIT2, 2, 0, 600, 2'b01, 2'b01, 0);
    check("init_done", 32'(fc_init_done), 1);
    check("all_active", 32'(dbg_ch_state), 32'h2a);
    check("p_hdr_limit", hlim(0), 40);
    check("np_data_limit", dlim(1), 500);
    check("hdr_infinite", 32'(hdr_infinite), 32'b100);
    check("data_infinite", 32'(data_infinite), 0);

    // UpdateFC checks
    send(T_UPD, 0, 45, 400, 2'b10, 2'b01, 1);
    check("scale_err_code", 32'(fc_err_code), 1);
    check("scale_limit_kept", hlim(0), 40);
    check("sticky_set", 32'(fc_err_sticky), 1);
    send(T_UPD, 2, 5, 600, 2'b01, 2'b01, 3);
    send(T_UPD, 2, 0, 700, 2'b01, 2'b01, 0);
    check("cpl_data_update", dlim(2), 700);
    send(T_UPD, 0, 168, 400, 2'b01, 2'b01, 2);
    check("over_limit_kept", hlim(0), 40);
    send(T_UPD, 0, 167, 400, 2'b01, 2'b01, 0);
    check("delta_127_ok", hlim(0), 167);
    send(T_RSVD, 0, 0, 0, 2'b00, 2'b00, 0);
    send(T_UPD, 3, 0, 0, 2'b00, 2'b00, 0);

    // checking disabled: no report, no state change
    fc_chk_en = 1'b0;
    send(T_UPD, 0, 170, 400, 2'b11, 2'b01, 0);
    fc_chk_en = 1'b1;
    check("chk_dis_limit_kept", hlim(0), 167);
    check("err_code_held", {fc_err_ch, fc_err_code}, {2'd0, 3'd2});

    // sticky clear, then clear colliding with an error
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("sticky_cleared", 32'(fc_err_sticky), 0);
    err_clr = 1'b1;
    send(T_UPD, 0, 167, 400, 2'b10, 2'b01, 1);
    err_clr = 1'b0;
    check("sticky_set_wins", 32'(fc_err_sticky), 1);

    // link drop: everything IDLE, DLLPs ignored
    link_up = 1'b0;
    send(T_UPD, 1, 0, 0, 2'b01, 2'b01, 0);
    check("linkdown_state", 32'(dbg_ch_state), 0);
    check("linkdown_init_done", 32'(fc_init_done), 0);
    link_up = 1'b1;
    send(T_INIT1, 0, 100, 32000, 2'b01, 2'b11, 0);
    link_up = 1'b0;
    idle(1);
    check("linkdown_mid_init", 32'(dbg_ch_state), 0);
    check("sticky_kept", 32'(fc_err_sticky), 1);
    link_up = 1'b1;

    // data wrap arithmetic with scale 11
    send(T_INIT1, 0, 100, 32000, 2'b01, 2'b11, 0);
    send(T_INIT2, 0, 100, 32000, 2'b01, 2'b11, 0);
    send(T_UPD,   0, 100, 60000, 2'b01, 2'b11, 0);
    send(T_UPD,   0, 100, 65530, 2'b01, 2'b11, 0);
    check("data_65530", dlim(0), 65530);
    send(T_UPD,   0, 100, 100, 2'b01, 2'b11, 0);
    check("wrap_delta_106", dlim(0), 100);
    send(T_UPD,   0, 100, 99, 2'b01, 2'b11, 2);
    check("wrap_back_kept", dlim(0), 100);
    send(T_INIT2, 0, 1, 1, 2'b01, 2'b01, 0);
    check("active_init_ignored", cst(0), 2);

    // InitFC1 over limit boundary
    send(T_INIT1, 1, 128, 5, 2'b01, 2'b01, 2);
    check("init1_over_idle", cst(1), 0);
    send(T_INIT1, 1, 127, 2047, 2'b01, 2'b01, 0);
    check("init1_max_ok", cst(1), 1);

    idle(3);
    check("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
